// File: rtl/float_to_int_stream_if.sv
// Stream bundle for the float -> int converter: packed-float input side, integer output side.
// Handshake: a beat moves on a rising clk edge where valid && ready are both high; data is
// sampled only on that edge, valid may be withdrawn before a transfer, ready may change freely.
interface float_to_int_stream_if #(
  parameter int MANTISSA_SIZE = 23,
  parameter int EXPONENT_SIZE = 8,
  parameter int INT_SIZE      = 32
);
  logic                                 s_valid;
  logic                                 s_ready;
  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] s_data;
  logic                                 m_valid;
  logic                                 m_ready;
  logic [INT_SIZE-1:0]                  m_data;
  logic                                 m_overflow;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_overflow
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_overflow
  );
endinterface

// File: rtl/float_to_int_stream.sv
// Three-stage float -> signed integer converter (unpack/classify, shift, negate/saturate),
// truncating toward zero and saturating on overflow, with one global advance for all stages.
module float_to_int_stream #(
  parameter int MANTISSA_SIZE        = 23,
  parameter int EXPONENT_SIZE        = 8,
  parameter int EXPONENT_BIAS_OFFSET = 0,
  parameter int INT_SIZE             = 32
) (
  input  logic            clk,
  input  logic            reset,
  float_to_int_stream_if.slave bus
);
  localparam int EW   = EXPONENT_SIZE + 2;
  // The result is float * 2**OFFSET, so the scale factor lowers the effective bias.
  localparam int BIAS = 2**(EXPONENT_SIZE-1) - 1 - EXPONENT_BIAS_OFFSET;
  localparam int SW   = $clog2(INT_SIZE);

  localparam logic [INT_SIZE-1:0] INT_MAX = {1'b0, {(INT_SIZE-1){1'b1}}};
  localparam logic [INT_SIZE-1:0] INT_MIN = {1'b1, {(INT_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    K_ZERO = 2'd0,
    K_SAT  = 2'd1,
    K_MIN  = 2'd2,
    K_NORM = 2'd3
  } kind_t;

  logic                     ready_en;
  logic                     adv;
  logic                     accept;

  logic                     in_sign;
  logic [EXPONENT_SIZE-1:0] in_exp;
  logic [MANTISSA_SIZE-1:0] in_mant;
  logic signed [EW-1:0]     e_unb;
  kind_t                    kind_d;
  logic                     ovf_d;

  logic                     s1_valid;
  kind_t                    s1_kind;
  logic                     s1_sign;
  logic                     s1_ovf;
  logic [MANTISSA_SIZE-1:0] s1_mant;
  logic [SW-1:0]            s1_shift;

  logic [INT_SIZE-1:0]      mag_d;

  logic                     s2_valid;
  kind_t                    s2_kind;
  logic                     s2_sign;
  logic                     s2_ovf;
  logic [INT_SIZE-1:0]      s2_mag;

  logic [INT_SIZE-1:0]      res_d;

  logic                     out_valid;
  logic [INT_SIZE-1:0]      out_data;
  logic                     out_ovf;

  // ready_en keeps the input closed until the first edge after reset release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  assign adv         = !out_valid || bus.m_ready;
  assign accept      = bus.s_valid && bus.s_ready;
  assign bus.s_ready = adv && ready_en;

  // ---------------- S1: unpack and classify ----------------
  assign {in_sign, in_exp, in_mant} = bus.s_data;
  assign e_unb = $signed({2'b00, in_exp}) - $signed(EW'(BIAS));

  always_comb begin
    kind_d = K_NORM;
    ovf_d  = 1'b0;
    if (&in_exp) begin
      ovf_d  = 1'b1;
      kind_d = (in_mant != '0) ? K_ZERO : K_SAT;
    end else if (in_exp == '0 || e_unb < 0) begin
      kind_d = K_ZERO;
    end else if (e_unb > $signed(EW'(INT_SIZE-2))) begin
      // Exactly -2**(INT_SIZE-1) is representable; everything else out here saturates.
      if (in_sign && e_unb == $signed(EW'(INT_SIZE-1)) && in_mant == '0) begin
        kind_d = K_MIN;
      end else begin
        kind_d = K_SAT;
        ovf_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_kind  <= K_ZERO;
      s1_sign  <= 1'b0;
      s1_ovf   <= 1'b0;
      s1_mant  <= '0;
      s1_shift <= '0;
    end else if (adv) begin
      s1_valid <= accept;
      if (accept) begin
        s1_kind  <= kind_d;
        s1_sign  <= in_sign;
        s1_ovf   <= ovf_d;
        s1_mant  <= in_mant;
        s1_shift <= e_unb[SW-1:0];
      end
    end
  end

  // ---------------- S2: align the significand ----------------
  always_comb begin
    logic [INT_SIZE-1:0] sig_ext;
    int                  sh;
    sig_ext = INT_SIZE'({1'b1, s1_mant});
    sh      = int'(s1_shift);
    mag_d   = '0;
    if (s1_kind == K_NORM) begin
      if (sh >= MANTISSA_SIZE) mag_d = sig_ext << (sh - MANTISSA_SIZE);
      else                     mag_d = sig_ext >> (MANTISSA_SIZE - sh);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_kind  <= K_ZERO;
      s2_sign  <= 1'b0;
      s2_ovf   <= 1'b0;
      s2_mag   <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_kind <= s1_kind;
        s2_sign <= s1_sign;
        s2_ovf  <= s1_ovf;
        s2_mag  <= mag_d;
      end
    end
  end

  // ---------------- S3: negate / saturate into the output registers ----------------
  always_comb begin
    res_d = '0;
    case (s2_kind)
      K_ZERO:  res_d = '0;
      K_SAT:   res_d = s2_sign ? INT_MIN : INT_MAX;
      K_MIN:   res_d = INT_MIN;
      K_NORM:  res_d = s2_sign ? -s2_mag : s2_mag;
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= res_d;
        out_ovf  <= s2_ovf;
      end
    end
  end

  assign bus.m_valid    = out_valid;
  assign bus.m_data     = out_data;
  assign bus.m_overflow = out_ovf;
endmodule

// File: tb/tb_float_to_int_stream.sv
// Self-checking bench for float_to_int_stream: directed vectors, scaled (OFFSET=8) instance,
// back-pressure, randomized streaming against a value-level model, and reset with data in flight.
module tb_float_to_int_stream;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  logic [32:0] exp_q[$];
  logic [32:0] exp8_q[$];

  float_to_int_stream_if #(.MANTISSA_SIZE(23), .EXPONENT_SIZE(8), .INT_SIZE(32)) bus ();
  float_to_int_stream_if #(.MANTISSA_SIZE(23), .EXPONENT_SIZE(8), .INT_SIZE(32)) bus8 ();

  float_to_int_stream #(.MANTISSA_SIZE(23), .EXPONENT_SIZE(8),
                        .EXPONENT_BIAS_OFFSET(0), .INT_SIZE(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  float_to_int_stream #(.MANTISSA_SIZE(23), .EXPONENT_SIZE(8),
                        .EXPONENT_BIAS_OFFSET(8), .INT_SIZE(32)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model: value = float * 2**off, truncated, clamped ----------------
  function automatic logic [32:0] ref_conv(input logic [31:0] f, input int off);
    logic   sgn;
    int     ex;
    int     e;
    longint mant;
    longint mag;
    longint v;
    sgn  = f[31];
    ex   = int'(f[30:23]);
    mant = longint'(f[22:0]);
    if (ex == 255) begin
      if (mant != 0) return {1'b1, 32'h0000_0000};
      return {1'b1, sgn ? 32'h8000_0000 : 32'h7FFF_FFFF};
    end
    if (ex == 0) return 33'h0;
    e = ex - 127 + off;
    if (e < 0) return 33'h0;
    if (e > 38) return {1'b1, sgn ? 32'h8000_0000 : 32'h7FFF_FFFF};
    mag = ((64'sd1 <<< 23) + mant) <<< e;
    mag = mag >>> 23;
    v   = sgn ? -mag : mag;
    if (v > 64'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
    if (v < -64'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, v[31:0]};
  endfunction

  // Float encoding of x * 2**-8 (what an int->float stage at OFFSET=8 produces), |x| < 2**24.
  function automatic logic [31:0] int_to_float_q8(input int x);
    int          a;
    int          p;
    logic [31:0] r;
    if (x == 0) return 32'h0;
    a = (x < 0) ? -x : x;
    p = 0;
    for (int i = 0; i < 24; i++) if (a[i]) p = i;
    r[31]    = (x < 0);
    r[30:23] = 8'(p - 8 + 127);
    r[22:0]  = 23'((a << (23 - p)) & 32'h007F_FFFF);
    return r;
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] sp[12];
    logic [31:0] r;
    sp = '{32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0001, 32'h0000_0000,
           32'h8000_0000, 32'h0000_0005, 32'hCF00_0000, 32'hCF00_0001,
           32'h4F00_0000, 32'h4EFF_FFFF, 32'hCEFF_FFFF, 32'h3F00_0000};
    r = $urandom();
    case ($urandom_range(0, 5))
      0:       return r;
      1:       return sp[$urandom_range(0, 11)];
      2:       r[30:23] = 8'($urandom_range(100, 165));
      default: r[30:23] = 8'($urandom_range(124, 160));
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] d, input logic r);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.m_ready = r;
    @(negedge clk);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset        = 1'b1;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.m_ready  = 1'b1;
    bus8.s_valid = 1'b0;
    bus8.s_data  = '0;
    bus8.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
    total++;
    if (bus.m_data !== 32'h0) begin bad++; $display("FAIL reset_m_data: got %h want 00000000", bus.m_data); end
    total++;
    if (bus.m_overflow !== 1'b0) begin bad++; $display("FAIL reset_m_overflow: got %b want 0", bus.m_overflow); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL reset_s_ready_early: got %b want 0", bus.s_ready); end
    next_edge();
    total++;
    if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL reset_s_ready_after: got %b want 1", bus.s_ready); end
  endtask

  task automatic test_latency();
    logic [31:0] vin[3];
    logic [31:0] vout[3];
    logic        want_v;
    vin  = '{32'h3F80_0000, 32'h4049_0FDB, 32'hC049_0FDB};
    vout = '{32'h0000_0001, 32'h0000_0003, 32'hFFFF_FFFD};
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive(cyc < 3, (cyc < 3) ? vin[cyc] : 32'h0, 1'b1);
      want_v = (cyc >= 3 && cyc <= 5);
      total++;
      if (bus.m_valid !== want_v) begin
        bad++;
        $display("FAIL latency_valid cyc%0d: got %b want %b", cyc, bus.m_valid, want_v);
      end
      if (want_v) begin
        total++;
        if ({bus.m_overflow, bus.m_data} !== {1'b0, vout[cyc-3]}) begin
          bad++;
          $display("FAIL latency_data cyc%0d: got ovf=%b %h want ovf=0 %h",
                   cyc, bus.m_overflow, bus.m_data, vout[cyc-3]);
        end
      end
      next_edge();
    end
  endtask

  task automatic test_special();
    logic [31:0] vin[9];
    logic [32:0] vout[9];
    logic [32:0] want;
    int          idx;
    int          cyc;
    vin  = '{32'h4F00_0000, 32'hCF00_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h0000_0001,
             32'h3F7F_FFFF, 32'hBF7F_FFFF, 32'h4EFF_FFFF, 32'hCF00_0001};
    vout = '{{1'b1, 32'h7FFF_FFFF}, {1'b0, 32'h8000_0000}, {1'b1, 32'h8000_0000},
             {1'b1, 32'h0000_0000}, {1'b0, 32'h0000_0000}, {1'b0, 32'h0000_0000},
             {1'b0, 32'h0000_0000}, {1'b0, 32'h7FFF_FF80}, {1'b1, 32'h8000_0000}};
    idx = 0;
    cyc = 0;
    while ((idx < 9 || exp_q.size() > 0) && cyc < 40) begin
      drive(idx < 9, (idx < 9) ? vin[idx] : 32'h0, 1'b1);
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back(vout[idx]);
        idx++;
      end
      if (bus.m_valid && bus.m_ready) begin
        total++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        if ({bus.m_overflow, bus.m_data} !== want) begin
          bad++;
          $display("FAIL special: got ovf=%b %h want ovf=%b %h",
                   bus.m_overflow, bus.m_data, want[32], want[31:0]);
        end
      end
      next_edge();
      cyc++;
    end
    bus.s_valid = 1'b0;
    total++;
    if (exp_q.size() != 0 || idx != 9) begin
      bad++;
      $display("FAIL special_drain: got %0d pending, %0d sent want 0 pending, 9 sent", exp_q.size(), idx);
      exp_q.delete();
    end
  endtask

  task automatic test_offset();
    logic [31:0] vin[22];
    logic [32:0] want;
    int          x;
    int          idx;
    int          cyc;
    vin[0] = 32'h3F80_0000;
    vin[1] = 32'h3B80_0000;
    for (int i = 2; i < 22; i++) begin
      x      = int'($urandom_range(0, 32'h01FF_FFFE)) - 32'sh00FF_FFFF;
      vin[i] = int_to_float_q8(x);
    end
    idx = 0;
    cyc = 0;
    bus8.m_ready = 1'b1;
    while ((idx < 22 || exp8_q.size() > 0) && cyc < 60) begin
      bus8.s_valid = (idx < 22);
      bus8.s_data  = (idx < 22) ? vin[idx] : 32'h0;
      @(negedge clk);
      if (bus8.s_valid && bus8.s_ready) begin
        if (idx == 0)      exp8_q.push_back({1'b0, 32'h0000_0100});
        else if (idx == 1) exp8_q.push_back({1'b0, 32'h0000_0001});
        else               exp8_q.push_back(ref_conv(vin[idx], 8));
        idx++;
      end
      if (bus8.m_valid) begin
        total++;
        want = (exp8_q.size() > 0) ? exp8_q.pop_front() : 33'h0;
        if ({bus8.m_overflow, bus8.m_data} !== want) begin
          bad++;
          $display("FAIL offset8: got ovf=%b %h want ovf=%b %h",
                   bus8.m_overflow, bus8.m_data, want[32], want[31:0]);
        end
      end
      next_edge();
      cyc++;
    end
    bus8.s_valid = 1'b0;
    total++;
    if (exp8_q.size() != 0 || idx != 22) begin
      bad++;
      $display("FAIL offset8_drain: got %0d pending want 0", exp8_q.size());
      exp8_q.delete();
    end
  endtask

  // Round trip int -> float(q8) -> int must be the identity for |x| < 2**24.
  task automatic test_round_trip_model();
    int          x;
    logic [32:0] got;
    for (int i = 0; i < 4; i++) begin
      x   = int'($urandom_range(0, 32'h01FF_FFFE)) - 32'sh00FF_FFFF;
      got = ref_conv(int_to_float_q8(x), 8);
      total++;
      if (got !== {1'b0, x[31:0]}) begin
        bad++;
        $display("FAIL round_trip_model: got %h want %h", got[31:0], x);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] items[6];
    logic [31:0] hold;
    logic [32:0] want;
    int          idx;
    int          delivered;
    int          cyc;
    for (int i = 0; i < 6; i++) begin
      items[i]        = $urandom();
      items[i][30:23] = 8'($urandom_range(127, 150));
    end
    idx  = 0;
    hold = '0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, items[idx], 1'b0);
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back(ref_conv(items[idx], 0));
        idx++;
      end
      if (c == 3) hold = bus.m_data;
      if (c == 4) begin
        total++;
        if (bus.m_data !== hold) begin bad++; $display("FAIL bp_stable: got %h want %h", bus.m_data, hold); end
        total++;
        if (bus.s_ready !== 1'b0) begin bad++; $display("FAIL bp_s_ready: got %b want 0", bus.s_ready); end
      end
      next_edge();
    end
    total++;
    if (idx != 3) begin bad++; $display("FAIL bp_accepts: got %0d want 3", idx); end
    delivered = 0;
    cyc       = 0;
    while ((idx < 6 || exp_q.size() > 0) && cyc < 40) begin
      drive(idx < 6, (idx < 6) ? items[idx] : 32'h0, 1'b1);
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back(ref_conv(items[idx], 0));
        idx++;
      end
      if (bus.m_valid && bus.m_ready) begin
        total++;
        delivered++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        if ({bus.m_overflow, bus.m_data} !== want) begin
          bad++;
          $display("FAIL bp_order: got ovf=%b %h want ovf=%b %h",
                   bus.m_overflow, bus.m_data, want[32], want[31:0]);
        end
      end
      next_edge();
      cyc++;
    end
    bus.s_valid = 1'b0;
    total++;
    if (delivered != 6) begin
      bad++;
      $display("FAIL bp_count: got %0d want 6", delivered);
      exp_q.delete();
    end
  endtask

  task automatic test_random();
    logic [32:0] want;
    logic [31:0] d;
    int          cyc;
    for (int c = 0; c < 400; c++) begin
      d = rand_float();
      drive($urandom_range(0, 99) < 75, d, $urandom_range(0, 99) < 70);
      if (bus.s_valid && bus.s_ready) exp_q.push_back(ref_conv(d, 0));
      if (bus.m_valid && bus.m_ready) begin
        total++;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 33'h0;
        if ({bus.m_overflow, bus.m_data} !== want) begin
          bad++;
          $display("FAIL random: got ovf=%b %h want ovf=%b %h",
                   bus.m_overflow, bus.m_data, want[32], want[31:0]);
        end
      end
      next_edge();
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 20) begin
      drive(1'b0, 32'h0, 1'b1);
      if (bus.m_valid && bus.m_ready) begin
        total++;
        want = exp_q.pop_front();
        if ({bus.m_overflow, bus.m_data} !== want) begin
          bad++;
          $display("FAIL random_drain: got ovf=%b %h want ovf=%b %h",
                   bus.m_overflow, bus.m_data, want[32], want[31:0]);
        end
      end
      next_edge();
      cyc++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL random_pending: got %0d want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_in_flight();
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 32'h4120_0000, 1'b0);
      next_edge();
    end
    drive(1'b0, 32'h0, 1'b0);
    total++;
    if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL flight_full: got m_valid=%b want 1", bus.m_valid); end
    reset = 1'b1;
    #1;
    total++;
    if ({bus.m_valid, bus.m_overflow, bus.m_data} !== 34'h0) begin
      bad++;
      $display("FAIL flight_async_clear: got v=%b ovf=%b %h want all 0", bus.m_valid, bus.m_overflow, bus.m_data);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    next_edge();
    total++;
    if (bus.s_ready !== 1'b1) begin bad++; $display("FAIL flight_s_ready: got %b want 1", bus.s_ready); end
    for (int c = 0; c < 8; c++) begin
      drive(1'b0, 32'h0, 1'b1);
      total++;
      if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL flight_stale cyc%0d: got m_valid=%b want 0", c, bus.m_valid); end
      next_edge();
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_latency();
    test_special();
    test_offset();
    test_round_trip_model();
    test_backpressure();
    test_random();
    test_reset_in_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
